// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the SCCPU load/store unit.
// Lives next to the ALU op defines; bit 3 of an op code marks a store.
package lsu_pkg;

    localparam logic [3:0] LSU_LB  = 4'd0;
    localparam logic [3:0] LSU_LBU = 4'd1;
    localparam logic [3:0] LSU_LH  = 4'd2;
    localparam logic [3:0] LSU_LHU = 4'd3;
    localparam logic [3:0] LSU_LW  = 4'd4;
    localparam logic [3:0] LSU_SB  = 4'd8;
    localparam logic [3:0] LSU_SH  = 4'd9;
    localparam logic [3:0] LSU_SW  = 4'd10;

    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    function automatic logic is_store(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic lsu_size_t size(input logic [3:0] op);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return SZ_H;
            LSU_LW, LSU_SW:          return SZ_W;
            default:                 return SZ_B;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW,
            LSU_SB, LSU_SH, LSU_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, replicated store data,
// load extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        mis
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = mem_rdata[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        be      = 4'b1111;
        st_data = wdata;
        ld_data = mem_rdata;
        mis     = 1'b0;
        case (size(op))
            SZ_B: begin
                if (is_store(op))
                    be = 4'b0001 << lane;
                st_data = {4{wdata[7:0]}};
                ld_data = (op == LSU_LB) ? {{24{ld_byte[7]}}, ld_byte}
                                         : {24'd0, ld_byte};
            end
            SZ_H: begin
                if (is_store(op))
                    be = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
                ld_data = (op == LSU_LH) ? {{16{ld_half[15]}}, ld_half}
                                         : {16'd0, ld_half};
                mis     = lane[0];
            end
            default: mis = (lane != 2'b00);
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage behind the ALU: runs one req/ack bus transaction per
// memory instruction, stalling the front end until it completes or times out.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [3:0]        op_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    lsu_state_t        state, state_nx;
    logic [7:0]        cnt;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [3:0]  sel_op;
    logic [1:0]  sel_lane;
    logic [31:0] sel_wdata;
    logic [3:0]  be;
    logic [31:0] st_data, ld_data;
    logic        mis, legal, issue, issue_bad, tmo;

    // Live inputs are only inspected in IDLE; during REQ the latched op drives the bus.
    assign sel_op    = (state == IDLE) ? op_type    : op_q;
    assign sel_lane  = (state == IDLE) ? addr[1:0]  : addr_q[1:0];
    assign sel_wdata = (state == IDLE) ? wdata      : wdata_q;

    lsu_align u_align (
        .op        (sel_op),
        .lane      (sel_lane),
        .wdata     (sel_wdata),
        .mem_rdata (mem_rdata),
        .be        (be),
        .st_data   (st_data),
        .ld_data   (ld_data),
        .mis       (mis)
    );

    assign legal     = op_valid && is_legal(op_type);
    assign issue     = (state == IDLE) && legal && !mis;
    assign issue_bad = (state == IDLE) && legal && mis;
    assign tmo       = (state == REQ) && !mem_ack && (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                stall = issue;
                if (issue)
                    state_nx = REQ;
            end
            REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = is_store(op_q);
                mem_be    = be;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata = st_data;
                if (mem_ack)
                    state_nx = DONE;
                else if (tmo)
                    state_nx = IDLE;
            end
            DONE: begin
                // op_valid here still belongs to the finishing instruction.
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            misalign <= issue_bad;
            bus_err  <= tmo;
            if (issue) begin
                op_q    <= op_type;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= '0;
            end
            if (state == REQ) begin
                cnt <= (mem_ack || tmo) ? 8'd0 : cnt + 8'd1;
                if (mem_ack && !is_store(op_q))
                    rdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed plus randomized bench for lsu_stage with an arithmetic reference model.
module tb_lsu_stage;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op_type;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_ack;
    logic        stall, done, misalign, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata = 32'd0;

    lsu_stage #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .done(done), .misalign(misalign), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 = illegal op.
    function automatic int sz(input logic [3:0] op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return 1;
            LSU_LH, LSU_LHU, LSU_SH: return 2;
            LSU_LW, LSU_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic exp_mis(input logic [3:0] op, input logic [31:0] a);
        return (sz(op) > 1) && ((a % 32'(sz(op))) != 0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
        if (!op[3] || sz(op) == 4) return 4'hF;
        if (sz(op) == 1) return 4'(1 << (a % 4));
        return ((a % 4) >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [3:0] op, input logic [31:0] wd);
        if (sz(op) == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz(op) == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        int unsigned lane = a % 4;
        int unsigned v;
        if (sz(op) == 1) begin
            v = (rd >> (8 * lane)) & 32'hFF;
            if (op == LSU_LB && v >= 128) v = v - 256;
        end else if (sz(op) == 2) begin
            v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
            if (op == LSU_LH && v >= 32768) v = v - 65536;
        end else
            v = rd;
        return v;
    endfunction

    // One instruction: issue in IDLE, ack after nwait REQ cycles (nwait >= TMO -> timeout).
    task automatic access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int nwait);
        @(posedge clk); #1;
        op_valid = 1'b1; op_type = op; addr = a; wdata = wd; mem_ack = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        if (sz(op) == 0 || exp_mis(op, a)) begin
            chk("nostall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            op_valid = 1'b0;
            @(negedge clk);
            chk("misalign", {31'd0, misalign}, {31'd0, (sz(op) != 0)});
            chk("noreq", {31'd0, mem_req}, 32'd0);
            chk("nostall2", {31'd0, stall}, 32'd0);
            return;
        end
        chk("stall_issue", {31'd0, stall}, 32'd1);
        chk("noreq_issue", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            mem_ack   = (k == nwait);
            mem_rdata = (k == nwait) ? rd : $urandom;
            @(negedge clk);
            chk("req", {31'd0, mem_req}, 32'd1);
            chk("stall_req", {31'd0, stall}, 32'd1);
            chk("we", {31'd0, mem_we}, {31'd0, op[3]});
            chk("be", {28'd0, mem_be}, {28'd0, exp_be(op, a)});
            chk("maddr", mem_addr, a & ~32'd3);
            if (op[3]) chk("mwdata", mem_wdata, exp_wd(op, wd));
            chk("nodone_req", {31'd0, done}, 32'd0);
            if (k == nwait) break;
            if (k < TMO - 1) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        if (nwait < TMO) begin
            op_valid = 1'b1;
            if (!op[3]) exp_rdata = exp_ld(op, a, rd);
        end
        @(negedge clk);
        chk("done", {31'd0, done}, {31'd0, (nwait < TMO)});
        chk("bus_err", {31'd0, bus_err}, {31'd0, (nwait >= TMO)});
        chk("stall_end", {31'd0, stall}, 32'd0);
        chk("req_end", {31'd0, mem_req}, 32'd0);
        chk("rdata", rdata, exp_rdata);
        @(posedge clk); #1;
        op_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_err", {31'd0, bus_err}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_req", {31'd0, mem_req}, 32'd0);
    endtask

    logic [3:0] ops [10];

    initial begin
        ops = '{LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW, LSU_SB, LSU_SH, LSU_SW, 4'd5, 4'd15};
        rst = 1'b1; op_valid = 1'b0; op_type = 4'd0; addr = 32'd0; wdata = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_flags", {29'd0, misalign, bus_err, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        access(LSU_LW,  32'h10, 32'h0, 32'hDEADBEEF, 0);
        access(LSU_LB,  32'h13, 32'h0, 32'h80FF1234, 0);
        access(LSU_LBU, 32'h13, 32'h0, 32'h80FF1234, 0);
        access(LSU_SH,  32'h22, 32'h0000ABCD, 32'h0, 3);
        access(LSU_LW,  32'h06, 32'h0, 32'h0, 0);
        access(LSU_SH,  32'h05, 32'h0, 32'h0, 0);
        access(LSU_SW,  32'h30, 32'h12345678, 32'h0, TMO);
        access(4'd5,    32'h40, 32'h0, 32'h0, 0);

        // Reset in the second REQ cycle, followed by a stale ack.
        @(posedge clk); #1;
        op_valid = 1'b1; op_type = LSU_LW; addr = 32'h40;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        exp_rdata = 32'd0;
        @(negedge clk);
        chk("post_rst_out", {stall, done, misalign, bus_err, mem_req, mem_we, mem_be},
            10'd0);
        chk("post_rst_addr", mem_addr | mem_wdata | rdata, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stale_ack_done", {31'd0, done}, 32'd0);
        access(LSU_LW, 32'h44, 32'h0, 32'h01234567, 1);

        for (int n = 0; n < 60; n++) begin
            access(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
                   int'($urandom_range(0, TMO)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit placed directly downstream of the ALU in the SCCPU datapath.
- Takes the ALU result (C) as the effective address and the rt value as store data.
- Runs a req/ack transaction on the data-memory bus and stalls the PC and register file while the access is outstanding.
- Returns byte/half/word-aligned, sign- or zero-extended load data for write-back, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: max cycles in REQ without mem_ack before the access is aborted (range 1..255).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  memory instruction present this cycle (from control unit)
- op_type  in  4  LSU_LB/LBU/LH/LHU/LW/SB/SH/SW (package encoding)
- addr  in  ADDR_W  effective address = ALU result C
- wdata  in  32  store data (rt)
- stall  out  1  freeze PC/IF and RF write
- rdata  out  32  extended load data, valid while done=1
- done  out  1  one-cycle pulse: access complete; RF writes rdata if load
- misalign  out  1  one-cycle pulse: misaligned access, no bus cycle issued
- bus_err  out  1  one-cycle pulse: TIMEOUT expired
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, sampled on the ack cycle
- mem_ack  in  1  slave completes the transfer this cycle

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE. All outputs are 0: stall, done, misalign, bus_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata. Timeout counter = 0.
- Little-endian lane order; lane index = addr[1:0].
- Misalignment rules:
  - Halfword op with addr[0]=1 is misaligned.
  - Word op with addr[1:0]!=0 is misaligned.
  - Byte ops are never misaligned.
- IDLE:
  - op_valid=1 and aligned: stall=1 combinationally in the same cycle. Latch op, addr and wdata; next state REQ.
  - op_valid=1 and misaligned: misalign=1 registered (next cycle); stall=0; no bus activity; state stays IDLE.
  - Any other op_type value (illegal): treated as op_valid=0.
- REQ:
  - mem_req=1; stall=1.
  - mem_we, mem_be, mem_addr and mem_wdata are held stable from latched values until ack.
  - On mem_ack=1: capture the extracted load data into rdata, clear the counter, next state DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ack: bus_err pulse next cycle, mem_req drops, next state IDLE, rdata unchanged.
- DONE:
  - done=1, stall=0; rdata is valid; next state IDLE.
  - op_valid is ignored in DONE. The CPU advances PC this cycle, so op_valid sampled in DONE belongs to the finished instruction.
- Latency: aligned access with ack in the first REQ cycle gives stall high for 2 cycles and done in the 3rd cycle.
- Byte enables: SB → 1<<addr[1:0]; SH → 4'b0011 or 4'b1100 by addr[1]; SW → 4'b1111; loads → 4'b1111 with mem_we=0.
- Store data: SB replicates wdata[7:0] ×4; SH replicates wdata[15:0] ×2; SW passes wdata.
- Load extraction:
  - Select the byte/half lane from mem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- mem_ack outside REQ is ignored.
- rst asserted in any state, including mid-REQ: next cycle everything is at reset values and mem_req=0. An abandoned slave ack afterwards is ignored.

Decomposition:
- Package lsu_pkg holds:
  - op_type encodings: LSU_LB=0, LSU_LBU=1, LSU_LH=2, LSU_LHU=3, LSU_LW=4, LSU_SB=8, LSU_SH=9, LSU_SW=10; bit3 = store.
  - State encoding IDLE/REQ/DONE.
  - Helpers is_store and size.
  - Add alongside the ALU op defines header.
- One sub-module: lsu_align. Purely combinational; it produces mem_be and mem_wdata, extracts load data and flags misalignment. The FSM and counter stay in lsu_stage.

Test Plan:
- LW addr=0x10, mem_rdata=0xDEADBEEF, ack in 1st REQ cycle → mem_be=4'hF, mem_we=0, done in cycle 3, rdata=0xDEADBEEF, stall high exactly 2 cycles.
- LB addr=0x13 with rdata 0x80FF1234, then LBU same address → mem_be=4'hF; LB gives rdata 0xFFFFFF80, LBU gives 0x00000080.
- SH addr=0x22, wdata=0x0000ABCD, ack after 3 wait cycles → mem_addr=0x20, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1 held stable across all REQ cycles.
- LW addr=0x06 → misalign pulse, mem_req never asserted, stall=0, state IDLE; SH addr=0x05 → misalign as well.
- SW with mem_ack held low, TIMEOUT=4 → mem_req high 4 cycles, then bus_err pulse, mem_req=0, done never asserted.
- rst asserted during the 2nd REQ cycle, then mem_ack=1 → outputs all 0, no done, next op_valid LW completes normally.
